// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: locks to 640x480@60 VGA sync timing and recovers pixel coordinates and colour.
// Define FRAME_CRC_EN to compute a per-frame CRC-16-CCITT of the captured pixels on FRAME_CRC.
module vga_sync_receiver #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_START     = 144,
    parameter int unsigned V_START     = 35,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SAMPLE_DIV  = 2,
    parameter int unsigned H_TOL       = 2,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        H_SYNC,
    input  logic        V_SYNC,
    input  logic        RED,
    input  logic        GREEN,
    input  logic        BLUE,
    output logic        LOCKED,
    output logic        PIXEL_VALID,
    output logic [9:0]  PIXEL_X,
    output logic [9:0]  PIXEL_Y,
    output logic [2:0]  PIXEL_RGB,
    output logic        FRAME_START,
    output logic [7:0]  ERR_CNT,
    output logic [15:0] FRAME_CRC
);

    localparam logic [12:0] LEN_MIN = 13'(H_TOTAL * SAMPLE_DIV - H_TOL);
    localparam logic [12:0] LEN_MAX = 13'(H_TOTAL * SAMPLE_DIV + H_TOL);
    localparam logic [11:0] TMO     = 12'(2 * H_TOTAL * SAMPLE_DIV);
    localparam logic [11:0] DIV     = 12'(SAMPLE_DIV);
    localparam logic [11:0] PHASE   = 12'(SAMPLE_DIV / 2);
    localparam logic [11:0] HS      = 12'(H_START);
    localparam logic [11:0] HE      = 12'(H_START + H_ACTIVE);
    localparam logic [9:0]  VS      = 10'(V_START);
    localparam logic [9:0]  VE      = 10'(V_START + V_ACTIVE);
    localparam logic [9:0]  VLAST   = 10'(V_TOTAL - 1);
    localparam logic [7:0]  LOCKN   = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  good_frames, good_nxt;
    logic        err_inc, fs_now;

    logic [4:0]  sync1, sync2;
    logic        hs_d, vs_d;
    logic        h_edge, v_edge;
    logic [11:0] hcyc;
    logic [9:0]  vline;
    logic [12:0] line_len;
    logic        line_ok, frame_ok, timeout;
    logic [11:0] pix, phase;
    logic        sample_hit;

    // RGB rides the same two-flop pipeline as the syncs so it stays aligned with them.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            sync1 <= '1;
            sync2 <= '1;
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
        end else begin
            sync1 <= {H_SYNC, V_SYNC, RED, GREEN, BLUE};
            sync2 <= sync1;
            hs_d  <= sync2[4];
            vs_d  <= sync2[3];
        end
    end

    assign h_edge = hs_d & ~sync2[4];
    assign v_edge = vs_d & ~sync2[3];

    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            hcyc  <= '0;
            vline <= '0;
        end else begin
            if (h_edge)
                hcyc <= '0;
            else if (hcyc != TMO)
                hcyc <= hcyc + 12'd1;
            if (v_edge)
                vline <= '0;
            else if (h_edge)
                vline <= vline + 10'd1;
        end
    end

    assign line_len   = {1'b0, hcyc} + 13'd1;
    assign line_ok    = (line_len >= LEN_MIN) && (line_len <= LEN_MAX);
    assign frame_ok   = (vline == VLAST);
    assign timeout    = (hcyc == TMO);
    assign pix        = hcyc / DIV;
    assign phase      = hcyc % DIV;
    assign sample_hit = (phase == PHASE) && (pix >= HS) && (pix < HE) &&
                        (vline >= VS) && (vline < VE);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            state       <= ST_SEARCH;
            good_frames <= '0;
        end else begin
            state       <= state_nxt;
            good_frames <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_frames;
        err_inc   = 1'b0;
        fs_now    = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (v_edge) begin
                    state_nxt = ST_MEASURE;
                    good_nxt  = '0;
                end
            end
            ST_MEASURE: begin
                if ((h_edge && !line_ok) || timeout) begin
                    state_nxt = ST_SEARCH;
                end else if (v_edge) begin
                    if (!frame_ok) begin
                        good_nxt = '0;
                    end else if (8'(good_frames + 8'd1) == LOCKN) begin
                        state_nxt = ST_LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_frames + 8'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if ((h_edge && !line_ok) || timeout || (v_edge && !frame_ok)) begin
                    state_nxt = ST_SEARCH;
                    err_inc   = 1'b1;
                end else if (v_edge) begin
                    fs_now = 1'b1;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    assign LOCKED = (state == ST_LOCKED);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            PIXEL_VALID <= 1'b0;
            PIXEL_X     <= '0;
            PIXEL_Y     <= '0;
            PIXEL_RGB   <= '0;
            FRAME_START <= 1'b0;
            ERR_CNT     <= '0;
        end else begin
            PIXEL_VALID <= LOCKED && sample_hit;
            FRAME_START <= fs_now;
            if (LOCKED && sample_hit) begin
                PIXEL_X   <= 10'(pix - HS);
                PIXEL_Y   <= vline - VS;
                PIXEL_RGB <= sync2[2:0];
            end
            if (err_inc && (ERR_CNT != 8'hFF))
                ERR_CNT <= ERR_CNT + 8'd1;
        end
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crc_acc;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic [7:0]  s;
        r = c;
        s = d;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[15] ^ s[7])
                r = {r[14:0], 1'b0} ^ 16'h1021;
            else
                r = {r[14:0], 1'b0};
            s = {s[6:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            crc_acc   <= 16'hFFFF;
            FRAME_CRC <= '0;
        end else if (FRAME_START) begin
            FRAME_CRC <= crc_acc;
            crc_acc   <= 16'hFFFF;
        end else if (PIXEL_VALID) begin
            crc_acc <= crc_byte(crc_acc, {5'b00000, PIXEL_RGB});
        end
    end
`else
    assign FRAME_CRC = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver using a scaled-down timing so whole frames stay short.
module tb_vga_sync_receiver;

    localparam int HT = 20, VT = 10, HS = 5, VS = 3, HA = 12, VA = 5;
    localparam int DIV = 2, TOL = 2, LOCKF = 2;
    localparam int LINE_CYC = HT * DIV;
    localparam int HSW = 6;
    localparam int VSW = 2;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b0;
    logic        H_SYNC = 1'b1, V_SYNC = 1'b1;
    logic        RED = 1'b0, GREEN = 1'b0, BLUE = 1'b0;
    logic        LOCKED, PIXEL_VALID, FRAME_START;
    logic [9:0]  PIXEL_X, PIXEL_Y;
    logic [2:0]  PIXEL_RGB;
    logic [7:0]  ERR_CNT;
    logic [15:0] FRAME_CRC;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] rgb;
    } pix_t;

    pix_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fs_count = 0;
    logic [15:0] crc_model = 16'hFFFF;
    logic [15:0] crc_exp = 16'h0000;

    always #5 CLOCK_50 = ~CLOCK_50;

    vga_sync_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .SAMPLE_DIV(DIV), .H_TOL(TOL),
        .LOCK_FRAMES(LOCKF)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .LOCKED(LOCKED),
        .PIXEL_VALID(PIXEL_VALID), .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y),
        .PIXEL_RGB(PIXEL_RGB), .FRAME_START(FRAME_START), .ERR_CNT(ERR_CNT),
        .FRAME_CRC(FRAME_CRC)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    always @(negedge CLOCK_50) begin : monitor
        pix_t e;
        if (FRAME_START) fs_count++;
        if (PIXEL_VALID) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel actual x=%0d y=%0d required=no strobe at %0t",
                         PIXEL_X, PIXEL_Y, $time);
            end else begin
                e = exp_q.pop_front();
                check("pixel_x", 32'(PIXEL_X), 32'(e.x));
                check("pixel_y", 32'(PIXEL_Y), 32'(e.y));
                check("pixel_rgb", 32'(PIXEL_RGB), 32'(e.rgb));
            end
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Pin cycle c of a line is seen by the receiver as hcyc = c-1, so pixel p spans c = 2p+1..2p+2.
    task automatic send_line(input int len, input int line, input bit vlow, input bit push);
        for (int c = 0; c < len; c++) begin
            int hc, p;
            logic [2:0] rgb;
            hc = c - 1;
            p = hc / DIV;
            rgb = (c == 0) ? 3'b000 : 3'(p + line);
            if (push && c >= 1 && (hc % DIV) == DIV / 2 && p >= HS && p < HS + HA &&
                line >= VS && line < VS + VA) begin
                exp_q.push_back('{x: 10'(p - HS), y: 10'(line - VS), rgb: rgb});
                crc_model = crc_upd(crc_model, {5'b00000, rgb});
            end
            H_SYNC = (c >= HSW);
            V_SYNC = !vlow;
            {RED, GREEN, BLUE} = rgb;
            step();
        end
    endtask

    task automatic send_frame(input int nlines, input int push_lines, input int odd_line,
                              input int odd_len);
        for (int l = 0; l < nlines; l++)
            send_line((l == odd_line) ? odd_len : LINE_CYC, l, l < VSW, l < push_lines);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            H_SYNC = 1'b1;
            V_SYNC = 1'b1;
            {RED, GREEN, BLUE} = 3'b000;
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        repeat (3) step();
        check("rst_locked", 32'(LOCKED), 0);
        check("rst_valid", 32'(PIXEL_VALID), 0);
        check("rst_err", 32'(ERR_CNT), 0);
        check("rst_fs", 32'(FRAME_START), 0);
        check("rst_x", 32'(PIXEL_X), 0);
        check("rst_crc", 32'(FRAME_CRC), 0);
        RESET = 1'b1;
        idle(10);

        // Nominal lock: first V edge, then two full good frames.
        send_frame(VT, 0, -1, 0);
        check("lock_after_f1", 32'(LOCKED), 0);
        send_frame(VT, 0, -1, 0);
        check("lock_after_f2", 32'(LOCKED), 0);
        crc_model = 16'hFFFF;
        send_frame(VT, VT, -1, 0);
        crc_exp = crc_model;
        check("lock_after_f3", 32'(LOCKED), 1);
        check("queue_f3", 32'(exp_q.size()), 0);
        check("fs_f3", 32'(fs_count), 0);

        // One line one cycle long is inside tolerance.
        send_frame(VT, VT, 4, LINE_CYC + 1);
        check("lock_tol_line", 32'(LOCKED), 1);
        check("err_tol_line", 32'(ERR_CNT), 0);
        check("queue_f4", 32'(exp_q.size()), 0);
        check("fs_f4", 32'(fs_count), 1);
`ifdef FRAME_CRC_EN
        check("frame_crc", 32'(FRAME_CRC), 32'(crc_exp));
`else
        check("frame_crc", 32'(FRAME_CRC), 0);
`endif

        // Line five cycles long drops lock at the following H edge.
        send_frame(VT, 5, 4, LINE_CYC + 5);
        check("lock_bad_line", 32'(LOCKED), 0);
        check("err_bad_line", 32'(ERR_CNT), 1);
        check("queue_f5", 32'(exp_q.size()), 0);
        check("fs_f5", 32'(fs_count), 2);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        check("relock_pending", 32'(LOCKED), 0);
        send_frame(VT, VT, -1, 0);
        check("relock", 32'(LOCKED), 1);
        check("err_relock", 32'(ERR_CNT), 1);
        check("queue_f8", 32'(exp_q.size()), 0);

        // H_SYNC stuck high past the timeout.
        idle(2 * LINE_CYC + 20);
        check("lock_timeout", 32'(LOCKED), 0);
        check("err_timeout", 32'(ERR_CNT), 2);

        // Short frame during MEASURE clears the good-frame count.
        send_frame(VT, 0, -1, 0);
        send_frame(VT - 1, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        check("lock_short_f11", 32'(LOCKED), 0);
        send_frame(VT, 0, -1, 0);
        check("lock_short_f12", 32'(LOCKED), 0);
        send_frame(VT, VT, -1, 0);
        check("lock_short_f13", 32'(LOCKED), 1);
        check("err_short", 32'(ERR_CNT), 2);
        check("queue_f13", 32'(exp_q.size()), 0);
        check("fs_f13", 32'(fs_count), 2);

        // Mid-frame reset while locked.
        send_line(LINE_CYC, 0, 1'b1, 1'b0);
        send_line(LINE_CYC, 1, 1'b1, 1'b0);
        RESET = 1'b0;
        H_SYNC = 1'b1;
        V_SYNC = 1'b1;
        step();
        check("mrst_locked", 32'(LOCKED), 0);
        check("mrst_err", 32'(ERR_CNT), 0);
        check("mrst_valid", 32'(PIXEL_VALID), 0);
        check("mrst_x", 32'(PIXEL_X), 0);
        check("mrst_y", 32'(PIXEL_Y), 0);
        check("mrst_rgb", 32'(PIXEL_RGB), 0);
        check("mrst_fs", 32'(FRAME_START), 0);
        check("mrst_crc", 32'(FRAME_CRC), 0);
        RESET = 1'b1;
        idle(5);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        check("mrst_relock_pending", 32'(LOCKED), 0);
        send_frame(VT, VT, -1, 0);
        check("mrst_relock", 32'(LOCKED), 1);
        check("mrst_err_after", 32'(ERR_CNT), 0);
        check("queue_f17", 32'(exp_q.size()), 0);
        check("fs_total", 32'(fs_count), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
